// File: rtl/ex_mdu.sv
// ex_mdu: iterative multiply/divide unit for the EX stage.
// Runs MULT, MULTU, DIV and DIVU one bit per cycle over WIDTH cycles.
// The result is presented as {hi,lo}. While the result is pending, stallreq_o holds the pipeline.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   start_i     request; held high with stable operands until ready_o is seen
//   op_i        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   opdata1_i   multiplicand / dividend (rs)
//   opdata2_i   multiplier / divisor (rt)
//   annul_i     pipeline flush, abandons any operation in flight
//   result_o    {hi,lo}: full product, or {remainder, quotient}
//   ready_o     result_o is valid
//   stallreq_o  combinational stall request towards the pipeline
module ex_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  typedef enum logic [1:0] {IDLE, ZERO, BUSY, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;

  logic               sign1;
  logic               sign2;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] final_res;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     hi_sh;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign stallreq_o = start_i & ~ready_o & ~annul_i;

  // Operand magnitudes and signs. Only the signed ops (op_i[0]) ever see a negative operand.
  always_comb begin
    sign1 = op_i[0] & opdata1_i[WIDTH-1];
    sign2 = op_i[0] & opdata2_i[WIDTH-1];
    mag1  = sign1 ? -opdata1_i : opdata1_i;
    mag2  = sign2 ? -opdata2_i : opdata2_i;
  end

  // One iteration step on the accumulator, followed by the sign correction that is applied
  // after the last step.
  // Multiply: acc starts as {0, multiplier}. Each step conditionally adds the multiplicand into
  //   the high half, then shifts the whole accumulator right.
  // Divide: acc starts as {0, dividend}. Each step shifts left and tries to subtract the divisor
  //   from the high half; a successful subtraction shifts a quotient 1 into the low half.
  //   After WIDTH steps, hi holds the remainder and lo holds the quotient.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    hi_sh    = acc[2*WIDTH-1:WIDTH-1];
    diff     = hi_sh - {1'b0, opnd};
    acc_next = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH])
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {hi_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
    quo       = acc_next[WIDTH-1:0];
    rem       = acc_next[2*WIDTH-1:WIDTH];
    final_res = neg_res ? -acc_next : acc_next;
    if (is_div)
      final_res = {(neg_rem ? -rem : rem), (neg_res ? -quo : quo)};
  end

  // Control FSM plus the datapath registers. Reset takes priority over everything else,
  // then annul takes priority over start.
  // A divide by zero skips the iteration and returns {dividend, all-ones} via ZERO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (annul_i) begin
      state   <= IDLE;
      ready_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            if (op_i[1] && opdata2_i == '0) begin
              state <= ZERO;
            end else begin
              state   <= BUSY;
              cnt     <= '0;
              is_div  <= op_i[1];
              neg_res <= sign1 ^ sign2;
              neg_rem <= sign1;
              if (op_i[1]) begin
                acc  <= {{WIDTH{1'b0}}, mag1};
                opnd <= mag2;
              end else begin
                acc  <= {{WIDTH{1'b0}}, mag2};
                opnd <= mag1;
              end
            end
          end
        end
        ZERO: begin
          result_o <= {opdata1_i, {WIDTH{1'b1}}};
          ready_o  <= 1'b1;
          state    <= DONE;
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            result_o <= final_res;
            ready_o  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (!start_i) begin
            state   <= IDLE;
            ready_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed testbench for ex_mdu with hand-computed expected results.
// Inputs are driven 1ns after the rising edge. Outputs are sampled on the falling edge.
module tb_ex_mdu;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int          checks;
  int          errors;
  logic [63:0] last_result;

  ex_mdu #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  // Free-running clock with a 10ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives the request-side inputs as EX would.
  task automatic applyStimulus(input logic start, input logic [1:0] op,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic annul);
    start_i   = start;
    op_i      = op;
    opdata1_i = d1;
    opdata2_i = d2;
    annul_i   = annul;
  endtask

  // Compares one observed value against its expected value, and counts any miss.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Waits for ready_o while counting stall cycles, then checks the latency, the result and the
  // handshake. Finally it releases start_i and leaves the DUT in an IDLE cycle.
  task automatic waitResult(input string tag, input logic [63:0] exp_res, input int exp_lat);
    int cyc;
    int stalls;
    cyc    = 0;
    stalls = 0;
    @(negedge clk);
    while (!ready_o && cyc < 100) begin
      if (stallreq_o) stalls++;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 100) checkOutput({tag, " timeout"}, 64'd0, 64'd1);
    checkOutput({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    checkOutput({tag, " result"}, result_o, exp_res);
    checkOutput({tag, " stall cycles"}, 64'(stalls), 64'(exp_lat));
    checkOutput({tag, " stall with ready"}, 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({tag, " held ready"}, {63'd0, ready_o}, 64'd1);
    checkOutput({tag, " held result"}, result_o, exp_res);
    @(posedge clk); #1;
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput({tag, " ready drop"}, {63'd0, ready_o}, 64'd0);
    last_result = exp_res;
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [63:0] exp_res, input int exp_lat);
    applyStimulus(1'b1, op, d1, d2, 1'b0);
    waitResult(tag, exp_res, exp_lat);
  endtask

  // Directed sequence: reset, then the multiply and divide cases, divide by zero,
  // annul, and reset during an operation.
  initial begin
    checks      = 0;
    errors      = 0;
    last_result = 64'd0;
    rst         = 1'b1;
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset result", result_o, 64'd0);
    checkOutput("reset ready", {63'd0, ready_o}, 64'd0);
    checkOutput("reset stall", {63'd0, stallreq_o}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    runOp("mult -3*7",  2'b01, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 33);
    runOp("multu fffffffd*7", 2'b00, 32'hFFFF_FFFD, 32'd7, 64'h0000_0006_FFFF_FFEB, 33);
    runOp("multu max*max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);
    runOp("mult -1*-1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 33);
    runOp("divu 100/7", 2'b10, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    runOp("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    runOp("div 7/-2", 2'b11, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
    runOp("div minneg/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    runOp("divu by zero", 2'b10, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 2);

    // Annul a divide in cycle 10. The result must never appear, and the old result must be kept.
    applyStimulus(1'b1, 2'b10, 32'd1000, 32'd3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready_o) checkOutput("annul early ready", 64'd1, 64'd0);
      @(posedge clk); #1;
    end
    applyStimulus(1'b1, 2'b10, 32'd1000, 32'd3, 1'b1);
    @(negedge clk);
    checkOutput("annul stall", {63'd0, stallreq_o}, 64'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("annul ready", {63'd0, ready_o}, 64'd0);
    checkOutput("annul result kept", result_o, last_result);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ready_o) checkOutput("annul late ready", 64'd1, 64'd0);
    end
    @(posedge clk); #1;
    runOp("multu 5*6", 2'b00, 32'd5, 32'd6, 64'h0000_0000_0000_001E, 33);

    // Reset in cycle 15 of a MULT. With start_i held high, the operation restarts.
    applyStimulus(1'b1, 2'b01, 32'd12, 32'hFFFF_FFFB, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst result", result_o, 64'd0);
    checkOutput("midrst ready", {63'd0, ready_o}, 64'd0);
    rst = 1'b0;
    waitResult("mult 12*-5 restart", 64'hFFFF_FFFF_FFFF_FFC4, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
